// File: rtl/tile_scheduler_pkg.sv
// tile_scheduler shared types and defaults.
// State encodings and default widths for the GEMM tile sequencer.
package tile_scheduler_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DIM_W  = 16;
  localparam int DEF_CNT_W  = 32;

  typedef enum logic [1:0] {
    TS_IDLE  = 2'd0,
    TS_ISSUE = 2'd1,
    TS_WAIT  = 2'd2,
    TS_DONE  = 2'd3
  } ts_state_e;

endpackage

// File: rtl/tile_scheduler_if.sv
// Tile request channel between the scheduler and the array controller.
// master = scheduler, slave = array controller.
interface tile_scheduler_if
  import tile_scheduler_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              tile_req_valid;
  logic              tile_req_ready;
  logic [ADDR_W-1:0] tile_w_addr;
  logic [ADDR_W-1:0] tile_x_addr;
  logic [ADDR_W-1:0] tile_y_addr;
  logic              tile_acc_clear;
  logic              tile_writeback;
  logic              tile_done;

  modport master (
    output tile_req_valid,
    input  tile_req_ready,
    output tile_w_addr,
    output tile_x_addr,
    output tile_y_addr,
    output tile_acc_clear,
    output tile_writeback,
    input  tile_done
  );

  modport slave (
    input  tile_req_valid,
    output tile_req_ready,
    input  tile_w_addr,
    input  tile_x_addr,
    input  tile_y_addr,
    input  tile_acc_clear,
    input  tile_writeback,
    output tile_done
  );

endinterface

// File: rtl/tile_scheduler_addr_gen.sv
// Running-pointer address generator for the tile walk.
// Adders only; strobes come from the scheduler FSM.
module tile_addr_gen
  import tile_scheduler_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] w_stride,
  input  logic [ADDR_W-1:0] x_base,
  input  logic [ADDR_W-1:0] x_stride,
  input  logic [ADDR_W-1:0] y_base,
  input  logic [ADDR_W-1:0] y_stride,
  input  logic              step,
  input  logic              k_wrap,
  input  logic              n_wrap,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] x_addr,
  output logic [ADDR_W-1:0] y_addr
);

  logic [ADDR_W-1:0] w_base_q;
  logic [ADDR_W-1:0] w_stride_q;
  logic [ADDR_W-1:0] x_stride_q;
  logic [ADDR_W-1:0] y_stride_q;
  logic [ADDR_W-1:0] row_q;
  logic [ADDR_W-1:0] x_nxt;
  logic              m_wrap;

  assign x_nxt  = x_addr + x_stride_q;
  assign m_wrap = k_wrap & n_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_base_q   <= '0;
      w_stride_q <= '0;
      x_stride_q <= '0;
      y_stride_q <= '0;
      row_q      <= '0;
      w_addr     <= '0;
      x_addr     <= '0;
      y_addr     <= '0;
    end else if (load) begin
      w_base_q   <= w_base;
      w_stride_q <= w_stride;
      x_stride_q <= x_stride;
      y_stride_q <= y_stride;
      row_q      <= x_base;
      w_addr     <= w_base;
      x_addr     <= x_base;
      y_addr     <= y_base;
    end else if (step) begin
      w_addr <= m_wrap ? w_base_q
                       : w_addr + w_stride_q;
      // x rewinds per n; a new m row starts
      // right after the last x of the old one
      x_addr <= (k_wrap && !n_wrap) ? row_q
                                    : x_nxt;
      if (m_wrap)
        row_q <= x_nxt;
      if (k_wrap)
        y_addr <= y_addr + y_stride_q;
    end
  end

endmodule

// File: rtl/tile_scheduler.sv
// GEMM tile sequencer: walks M x N x K tiles (m, n, k order)
// and issues one request per tile to the array controller.
module tile_scheduler
  import tile_scheduler_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DIM_W  = DEF_DIM_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ap_start,
  input  logic [DIM_W-1:0]  cfg_m_tiles,
  input  logic [DIM_W-1:0]  cfg_n_tiles,
  input  logic [DIM_W-1:0]  cfg_k_tiles,
  input  logic [ADDR_W-1:0] cfg_w_base,
  input  logic [ADDR_W-1:0] cfg_w_stride,
  input  logic [ADDR_W-1:0] cfg_x_base,
  input  logic [ADDR_W-1:0] cfg_x_stride,
  input  logic [ADDR_W-1:0] cfg_y_base,
  input  logic [ADDR_W-1:0] cfg_y_stride,
  output logic              ap_idle,
  output logic              ap_done,
  tile_scheduler_if.master  tile,
  output logic [CNT_W-1:0]  tiles_done_cnt,
  output logic [1:0]        state_dbg
);

  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);
  localparam logic [DIM_W-1:0] TWO = DIM_W'(2);

  ts_state_e        state;
  ts_state_e        state_nx;
  ts_state_e        state_q;
  logic [DIM_W-1:0] m_num;
  logic [DIM_W-1:0] n_num;
  logic [DIM_W-1:0] k_num;
  logic [DIM_W-1:0] m_idx;
  logic [DIM_W-1:0] n_idx;
  logic [DIM_W-1:0] k_idx;
  logic             start;
  logic             zero_cfg;
  logic             hs;
  logic             fire;
  logic             last_k;
  logic             last_n;
  logic             last_m;
  logic             last_tile;
  logic             idle_d;
  logic             valid_d;
  logic             done_d;

  assign start    = (state == TS_IDLE) && ap_start;
  assign zero_cfg = (cfg_m_tiles == '0) ||
                    (cfg_n_tiles == '0) ||
                    (cfg_k_tiles == '0);
  assign hs       = tile.tile_req_valid &&
                    tile.tile_req_ready;
  assign fire     = (state == TS_WAIT) && tile.tile_done;

  assign last_k    = k_idx == k_num - ONE;
  assign last_n    = n_idx == n_num - ONE;
  assign last_m    = m_idx == m_num - ONE;
  assign last_tile = last_k && last_n && last_m;

  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= TS_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      state == TS_IDLE:
        if (ap_start)
          state_nx = zero_cfg ? TS_DONE : TS_ISSUE;
      state == TS_ISSUE:
        if (hs)
          state_nx = TS_WAIT;
      state == TS_WAIT:
        if (tile.tile_done)
          state_nx = last_tile ? TS_DONE : TS_ISSUE;
      state == TS_DONE:
        if (!ap_start)
          state_nx = TS_IDLE;
    endcase
  end

  // status outputs lag the state by one register stage;
  // valid alone drops on the accepting edge
  always_comb begin
    idle_d  = state == TS_IDLE;
    valid_d = (state == TS_ISSUE) && !hs;
    done_d  = (state == TS_DONE) &&
              (state_q != TS_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ap_idle             <= 1'b1;
      ap_done             <= 1'b0;
      tile.tile_req_valid <= 1'b0;
      state_q             <= TS_IDLE;
    end else begin
      ap_idle             <= idle_d;
      ap_done             <= done_d;
      tile.tile_req_valid <= valid_d;
      state_q             <= state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_num               <= '0;
      n_num               <= '0;
      k_num               <= '0;
      m_idx               <= '0;
      n_idx               <= '0;
      k_idx               <= '0;
      tiles_done_cnt      <= '0;
      tile.tile_acc_clear <= 1'b0;
      tile.tile_writeback <= 1'b0;
    end else if (start) begin
      m_num               <= cfg_m_tiles;
      n_num               <= cfg_n_tiles;
      k_num               <= cfg_k_tiles;
      m_idx               <= '0;
      n_idx               <= '0;
      k_idx               <= '0;
      tiles_done_cnt      <= '0;
      tile.tile_acc_clear <= 1'b1;
      tile.tile_writeback <= cfg_k_tiles == ONE;
    end else if (fire) begin
      tiles_done_cnt <= tiles_done_cnt + CNT_W'(1);
      k_idx <= last_k ? '0 : k_idx + ONE;
      if (last_k)
        n_idx <= last_n ? '0 : n_idx + ONE;
      if (last_k && last_n)
        m_idx <= last_m ? '0 : m_idx + ONE;
      tile.tile_acc_clear <= last_k;
      tile.tile_writeback <= last_k ? (k_num == ONE)
                                    : (k_idx == k_num - TWO);
    end
  end

  tile_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start),
    .w_base   (cfg_w_base),
    .w_stride (cfg_w_stride),
    .x_base   (cfg_x_base),
    .x_stride (cfg_x_stride),
    .y_base   (cfg_y_base),
    .y_stride (cfg_y_stride),
    .step     (fire),
    .k_wrap   (last_k),
    .n_wrap   (last_n),
    .w_addr   (tile.tile_w_addr),
    .x_addr   (tile.tile_x_addr),
    .y_addr   (tile.tile_y_addr)
  );

endmodule

// File: tb/tb_tile_scheduler.sv
// Scoreboard bench for tile_scheduler: stimulus pushes expected
// requests, a monitor pops and compares on every accepted request.
module tb_tile_scheduler;

  typedef struct packed {
    logic [15:0] w;
    logic [15:0] x;
    logic [15:0] y;
    logic        c;
    logic        b;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ap_start;
  logic [15:0] cfg_m_tiles, cfg_n_tiles, cfg_k_tiles;
  logic [15:0] cfg_w_base, cfg_w_stride;
  logic [15:0] cfg_x_base, cfg_x_stride;
  logic [15:0] cfg_y_base, cfg_y_stride;
  logic        ap_idle, ap_done;
  logic [31:0] tiles_done_cnt;
  logic [1:0]  state_dbg;

  tile_scheduler_if #(.ADDR_W(16)) tif ();

  tile_scheduler #(
    .ADDR_W (16),
    .DIM_W  (16),
    .CNT_W  (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ap_start       (ap_start),
    .cfg_m_tiles    (cfg_m_tiles),
    .cfg_n_tiles    (cfg_n_tiles),
    .cfg_k_tiles    (cfg_k_tiles),
    .cfg_w_base     (cfg_w_base),
    .cfg_w_stride   (cfg_w_stride),
    .cfg_x_base     (cfg_x_base),
    .cfg_x_stride   (cfg_x_stride),
    .cfg_y_base     (cfg_y_base),
    .cfg_y_stride   (cfg_y_stride),
    .ap_idle        (ap_idle),
    .ap_done        (ap_done),
    .tile           (tif.master),
    .tiles_done_cnt (tiles_done_cnt),
    .state_dbg      (state_dbg)
  );

  initial forever #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_chk = 0;
  int   n_pass = 0;
  req_t exp_q[$];
  req_t got_q[$];

  int   tie_rdy = 1;
  int   rdy_hold = 0;
  int   done_lat = 3;
  bit   spur_en = 1'b0;
  int   last_pulse_cyc = 0;
  int   pulse_cnt = 0;

  int   n_acc = 0;
  int   done_pulses = 0;
  int   done_hi = 0;
  int   done_cyc = 0;
  int   wait_entries = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h",
                  nm, act, exp);
  endtask

  task automatic push_model(input int mn, nn, kn,
                            input logic [15:0] wb, ws,
                            input logic [15:0] xb, xs,
                            input logic [15:0] yb, ys);
    req_t r;
    int   t;
    for (int m = 0; m < mn; m++)
      for (int n = 0; n < nn; n++)
        for (int k = 0; k < kn; k++) begin
          t = int'(wb) + (n * kn + k) * int'(ws);
          r.w = t[15:0];
          t = int'(xb) + (m * kn + k) * int'(xs);
          r.x = t[15:0];
          t = int'(yb) + (m * nn + n) * int'(ys);
          r.y = t[15:0];
          r.c = (k == 0);
          r.b = (k == kn - 1);
          exp_q.push_back(r);
        end
  endtask

  // array-controller model: ready policy and tile_done pulses
  initial begin : ctl
    int ph, dcnt, hold;
    bit pulse, spur, tgl;
    ph = 0; dcnt = 0; hold = 0; tgl = 1'b0;
    tif.tile_req_ready = 1'b0;
    tif.tile_done = 1'b0;
    forever begin
      @(negedge clk);
      pulse = 1'b0;
      if (!rst_n) begin
        ph = 0; hold = 0;
        tif.tile_req_ready = 1'b0;
        tif.tile_done = 1'b0;
        continue;
      end
      spur = spur_en && (ph == 0) && tgl;
      tgl = ~tgl;
      if (ph == 1) begin
        tif.tile_req_ready = (tie_rdy != 0);
        dcnt++;
        if (dcnt >= done_lat) begin
          pulse = 1'b1;
          ph = 0;
          last_pulse_cyc = cyc;
          pulse_cnt++;
        end
      end else if (tif.tile_req_valid) begin
        if (hold < rdy_hold) begin
          tif.tile_req_ready = 1'b0;
          hold++;
        end else begin
          tif.tile_req_ready = 1'b1;
        end
        if (tif.tile_req_ready) begin
          ph = 1; dcnt = 0; hold = 0;
        end
      end else begin
        tif.tile_req_ready = (tie_rdy != 0);
      end
      tif.tile_done = pulse | spur;
    end
  end

  initial begin : mon
    req_t e, g, snap;
    bit   pv, pd;
    logic [1:0] ps;
    int   seen;
    pv = 1'b0; pd = 1'b0; ps = 2'd0; seen = 0;
    snap = '0;
    forever begin
      @(negedge clk);
      #1;
      g.w = tif.tile_w_addr;
      g.x = tif.tile_x_addr;
      g.y = tif.tile_y_addr;
      g.c = tif.tile_acc_clear;
      g.b = tif.tile_writeback;
      if (tif.tile_req_valid && !pv) begin
        snap = g;
        if (pulse_cnt != seen) begin
          chk("req_gap", cyc - last_pulse_cyc, 2);
          seen = pulse_cnt;
        end
      end else if (tif.tile_req_valid) begin
        chk("hold_stable", {15'd0, g}, {15'd0, snap});
      end
      if (tif.tile_req_valid && tif.tile_req_ready) begin
        n_acc++;
        got_q.push_back(g);
        if (exp_q.size() == 0) begin
          chk("req_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("req_w", g.w, e.w);
          chk("req_x", g.x, e.x);
          chk("req_y", g.y, e.y);
          chk("req_clear", g.c, e.c);
          chk("req_wb", g.b, e.b);
        end
      end
      if (ap_done) begin
        done_hi++;
        if (!pd) begin
          done_pulses++;
          done_cyc = cyc;
          seen = pulse_cnt;
        end
      end
      if (state_dbg == 2'd2 && ps != 2'd2)
        wait_entries++;
      pv = tif.tile_req_valid;
      pd = ap_done;
      ps = state_dbg;
    end
  end

  task automatic run(input int mn, nn, kn,
                     input logic [15:0] wb, ws,
                     input logic [15:0] xb, xs,
                     input logic [15:0] yb, ys,
                     input bit corrupt);
    int t, d0, a0, w0, rc, tot;
    tot = mn * nn * kn;
    cfg_m_tiles = 16'(mn);
    cfg_n_tiles = 16'(nn);
    cfg_k_tiles = 16'(kn);
    cfg_w_base = wb; cfg_w_stride = ws;
    cfg_x_base = xb; cfg_x_stride = xs;
    cfg_y_base = yb; cfg_y_stride = ys;
    push_model(mn, nn, kn, wb, ws, xb, xs, yb, ys);
    d0 = done_pulses; a0 = n_acc; w0 = wait_entries;
    @(negedge clk);
    ap_start = 1'b1;
    rc = cyc;
    t = 0;
    if (tot != 0) begin
      @(negedge clk);
      chk("start_v0", tif.tile_req_valid, 0);
      chk("start_idle1", ap_idle, 1);
      @(negedge clk);
      chk("start_v1", tif.tile_req_valid, 1);
      chk("start_idle0", ap_idle, 0);
    end
    while (done_pulses == d0 && t < 800) begin
      @(negedge clk);
      t++;
      if (corrupt && t == 4) begin
        cfg_w_base = 16'hDEAD;
        cfg_x_stride = 16'h0BAD;
        cfg_k_tiles = 16'd1;
        cfg_m_tiles = 16'd5;
      end
    end
    chk("run_done_seen", done_pulses - d0, 1);
    if (tot != 0) rc = last_pulse_cyc;
    chk("done_latency", done_cyc - rc, 2);
    @(negedge clk);
    ap_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("tiles_cnt", tiles_done_cnt, tot);
    chk("idle_after", ap_idle, 1);
    chk("reqs_seen", n_acc - a0, tot);
    chk("wait_entries", wait_entries - w0, tot);
    chk("queue_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin : main
    int b, t, d0, a0;
    rst_n = 1'b0;
    ap_start = 1'b0;
    cfg_m_tiles = '0; cfg_n_tiles = '0; cfg_k_tiles = '0;
    cfg_w_base = '0; cfg_w_stride = '0;
    cfg_x_base = '0; cfg_x_stride = '0;
    cfg_y_base = '0; cfg_y_stride = '0;
    repeat (3) @(negedge clk);
    chk("rst_idle", ap_idle, 1);
    chk("rst_state", state_dbg, 0);
    chk("rst_done", ap_done, 0);
    chk("rst_valid", tif.tile_req_valid, 0);
    chk("rst_cnt", tiles_done_cnt, 0);
    chk("rst_w", tif.tile_w_addr, 0);
    chk("rst_x", tif.tile_x_addr, 0);
    chk("rst_y", tif.tile_y_addr, 0);
    chk("rst_clr", tif.tile_acc_clear, 0);
    chk("rst_wb", tif.tile_writeback, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    b = got_q.size();
    run(1, 1, 1, 16'h0100, 16'h0010, 16'h2000,
        16'h0020, 16'h4000, 16'h0040, 1'b0);
    if (got_q.size() > b) begin
      chk("t1_w", got_q[b].w, 16'h0100);
      chk("t1_x", got_q[b].x, 16'h2000);
      chk("t1_y", got_q[b].y, 16'h4000);
      chk("t1_cw", {got_q[b].c, got_q[b].b}, 2'b11);
    end else chk("t1_log", got_q.size(), b + 1);

    spur_en = 1'b1;
    b = got_q.size();
    run(2, 2, 3, 16'h0100, 16'h0010, 16'h2000,
        16'h0020, 16'h4000, 16'h0040, 1'b1);
    spur_en = 1'b0;
    if (got_q.size() >= b + 12) begin
      chk("r3_w", got_q[b + 2].w, 16'h0120);
      chk("r3_x", got_q[b + 2].x, 16'h2040);
      chk("r3_y", got_q[b + 2].y, 16'h4000);
      chk("r3_wb", got_q[b + 2].b, 1);
      chk("r4_w", got_q[b + 3].w, 16'h0130);
      chk("r4_x", got_q[b + 3].x, 16'h2000);
      chk("r4_clr", got_q[b + 3].c, 1);
      chk("r12_w", got_q[b + 11].w, 16'h0150);
      chk("r12_x", got_q[b + 11].x, 16'h20A0);
      chk("r12_y", got_q[b + 11].y, 16'h40C0);
    end else chk("t2_log", got_q.size(), b + 12);

    tie_rdy = 0;
    rdy_hold = 5;
    run(1, 2, 2, 16'h0100, 16'h0010, 16'h2000,
        16'h0020, 16'h4000, 16'h0040, 1'b0);
    tie_rdy = 1;
    rdy_hold = 0;

    spur_en = 1'b1;
    run(3, 2, 0, 16'h0100, 16'h0010, 16'h2000,
        16'h0020, 16'h4000, 16'h0040, 1'b0);
    spur_en = 1'b0;

    cfg_m_tiles = 16'd2; cfg_n_tiles = 16'd2;
    cfg_k_tiles = 16'd3;
    cfg_w_base = 16'h0100; cfg_w_stride = 16'h0010;
    cfg_x_base = 16'h2000; cfg_x_stride = 16'h0020;
    cfg_y_base = 16'h4000; cfg_y_stride = 16'h0040;
    push_model(2, 2, 3, 16'h0100, 16'h0010, 16'h2000,
               16'h0020, 16'h4000, 16'h0040);
    a0 = n_acc;
    @(negedge clk);
    ap_start = 1'b1;
    t = 0;
    while (n_acc < a0 + 5 && t < 400) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("pre_rst_state", state_dbg, 2);
    chk("pre_rst_cnt", tiles_done_cnt, 4);
    d0 = done_pulses;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_idle", ap_idle, 1);
    chk("mid_rst_cnt", tiles_done_cnt, 0);
    chk("mid_rst_state", state_dbg, 0);
    chk("mid_rst_valid", tif.tile_req_valid, 0);
    chk("mid_rst_w", tif.tile_w_addr, 0);
    ap_start = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_no_done", done_pulses - d0, 0);
    run(1, 1, 1, 16'h0100, 16'h0010, 16'h2000,
        16'h0020, 16'h4000, 16'h0040, 1'b0);

    b = got_q.size();
    run(1, 1, 2, 16'hFFF0, 16'h0010, 16'h2000,
        16'h0020, 16'h4000, 16'h0040, 1'b0);
    if (got_q.size() >= b + 2)
      chk("wrap_w", got_q[b + 1].w, 16'h0000);
    else chk("wrap_log", got_q.size(), b + 2);

    chk("done_width", done_hi, done_pulses);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
